// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the writeback register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int ZERO_REG       = 0;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write bit vector with set-over-clear priority and the
//               RAW hazard compare for both read ports. REGFILE_BYPASS_EN
//               masks a port's hazard when its producer retires this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              hazard
);

  localparam int              NREG      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            rs_hit;
  logic            rt_hit;

  // Set is applied after clear: a newer producer keeps the entry pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    rs_hit = (rs_addr != ZERO_ADDR) && pending_q[rs_addr];
    rt_hit = (rt_addr != ZERO_ADDR) && pending_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (clr_en && (clr_addr == rs_addr) && !(set_en && (set_addr == rs_addr))) rs_hit = 1'b0;
    if (clr_en && (clr_addr == rt_addr) && !(set_en && (set_addr == rt_addr))) rt_hit = 1'b0;
`endif
    hazard = rs_hit | rt_hit;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sink.sv
// ============================================================================
// Module      : regfile_wb_sink
// Description : Register file terminating the writeback path; sequential
//               clear after reset, two combinational read ports, RAW
//               scoreboard. Optional forwarding macro: REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_sink
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              hazard,
  output logic              busy
);

  localparam int                NREG      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [ADDR_W-1:0]   clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [NREG];
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                accept;
  logic                run;
  logic                sb_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = clr_cnt_q;
    mem_wdata_d = '0;
    wb_ready    = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we_d  = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        wb_ready = 1'b1;
        busy     = 1'b0;
        accept   = wb_valid;
        // Register 0 accepts the handshake but never stores anything.
        if (wb_valid && (wb_addr != ZERO_ADDR)) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr;
          mem_wdata_d = wb_data;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_addr_d] <= mem_wdata_d;
  end

  assign run = (state_q == RUN);

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (run && (rs_addr != ZERO_ADDR)) rs_data = mem_q[rs_addr];
    if (run && (rt_addr != ZERO_ADDR)) rt_data = mem_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (accept && (wb_addr != ZERO_ADDR) && (wb_addr == rs_addr)) rs_data = wb_data;
    if (accept && (wb_addr != ZERO_ADDR) && (wb_addr == rt_addr)) rt_data = wb_data;
`endif
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid && run),
    .set_addr (issue_rd),
    .clr_en   (accept),
    .clr_addr (wb_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .hazard   (sb_hazard)
  );

  // Decode must stall while the array is still being cleared.
  assign hazard = !run | sb_hazard;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sink.sv
// ============================================================================
// Module      : tb_regfile_wb_sink
// Description : Self-checking bench for regfile_wb_sink against an array and
//               pending-set reference model. Honours REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_sink;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_ready;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          hazard;
  logic          busy;

  regfile_wb_sink #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hazard      (hazard),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit            m_busy = 1'b1;
  int            m_clr  = 0;
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic bit bypass_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return !m_busy && wb_valid && (a != 0) && (wb_addr == a);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_busy || a == 0) return '0;
    if (bypass_hit(a))    return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit port_hz(input logic [AW-1:0] a);
    if (a == 0 || !m_pend[a]) return 1'b0;
    if (bypass_hit(a) && !(issue_valid && issue_rd == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_hz();
    if (m_busy) return 1'b1;
    return port_hz(rs_addr) | port_hz(rt_addr);
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_clr  = 0;
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (m_busy) begin
      m_regs[m_clr] = '0;
      m_clr++;
      if (m_clr == NR) m_busy = 1'b0;
    end else begin
      if (wb_valid) begin
        if (wb_addr != 0) m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wb_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b1 || wb_ready !== 1'b0 || hazard !== 1'b1 || rs_data !== '0 || rt_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b ready=%b hazard=%b rs=%h rt=%h expected 1 0 1 0 0",
               busy, wb_ready, hazard, rs_data, rt_data);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic run_clear(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n_checks++;
      if (wb_ready !== 1'b0 || hazard !== 1'b1 || rs_data !== '0) begin
        n_fail++;
        $display("FAIL clear_outputs: got ready=%b hazard=%b rs=%h expected 0 1 0", wb_ready, hazard, rs_data);
      end
      cycles++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset();
    int c;
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1 apply_reset();
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = $urandom;
    run_clear(c);
    n_checks++;
    if (c != 32) begin
      n_fail++;
      $display("FAIL clear_length: got %0d cycles expected 32", c);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry: got busy=%b ready=%b expected 0 1", busy, wb_ready);
    end
    tick();
    for (int a = 0; a < NR; a++) begin
      rs_addr = AW'(a);
      rt_addr = AW'(NR - 1 - a);
      @(negedge clk);
      n_checks++;
      if (rs_data !== '0 || rt_data !== '0) begin
        n_fail++;
        $display("FAIL cleared_read: addr %0d got rs=%h rt=%h expected 0", a, rs_data, rt_data);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'hDEADBEEF;
    rs_addr  = 5'd5;
    @(negedge clk);
    n_checks++;
    if (rs_data !== exp_rd(rs_addr)) begin
      n_fail++;
      $display("FAIL write5_accept_cycle: got %h expected %h", rs_data, exp_rd(rs_addr));
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rs_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write5_read: got %h expected deadbeef", rs_data);
    end
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'h1234;
    rt_addr  = 5'd0;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (rt_data !== '0) begin
      n_fail++;
      $display("FAIL write0_read: got %h expected 0", rt_data);
    end
    tick();
  endtask

  task automatic test_hazard();
    logic [DW-1:0] d;
    d = $urandom;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs_addr     = 5'd7;
    rt_addr     = 5'd0;
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_issue_cycle: got %b expected 0", hazard);
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_pending: got %b expected 1", hazard);
    end
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = d;
    @(negedge clk);
    n_checks++;
    if (hazard !== exp_hz() || rs_data !== exp_rd(rs_addr)) begin
      n_fail++;
      $display("FAIL hazard_accept_cycle: got hazard=%b rs=%h expected %b %h",
               hazard, rs_data, exp_hz(), exp_rd(rs_addr));
    end
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b0 || rs_data !== d) begin
      n_fail++;
      $display("FAIL hazard_after_accept: got hazard=%b rs=%h expected 0 %h", hazard, rs_data, d);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    d = $urandom;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    wb_valid    = 1'b1;
    wb_addr     = 5'd9;
    wb_data     = d;
    rs_addr     = 5'd0;
    rt_addr     = 5'd9;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b1 || rt_data !== d) begin
      n_fail++;
      $display("FAIL same_cycle_set_wins: got hazard=%b rt=%h expected 1 %h", hazard, rt_data, d);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = d;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_release: got %b expected 0", hazard);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    rs_addr     = 5'd0;
    rt_addr     = 5'd0;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b0 || rs_data !== '0) begin
      n_fail++;
      $display("FAIL zero_reg_no_hazard: got hazard=%b rs=%h expected 0 0", hazard, rs_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_addr     = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, 7));
      rs_addr     = AW'($urandom_range(0, 7));
      rt_addr     = AW'($urandom_range(0, 7));
      @(negedge clk);
      n_checks++;
      if (rs_data !== exp_rd(rs_addr) || rt_data !== exp_rd(rt_addr) || hazard !== exp_hz()
          || wb_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: got rs=%h rt=%h hz=%b rdy=%b busy=%b expected %h %h %b 1 0",
                 i, rs_data, rt_data, hazard, wb_ready, busy,
                 exp_rd(rs_addr), exp_rd(rt_addr), exp_hz());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_clear();
    int c;
    apply_reset();
    repeat (10) tick();
    n_checks++;
    if (busy !== 1'b1 || m_clr != 10) begin
      n_fail++;
      $display("FAIL mid_clear_state: got busy=%b model_cnt=%0d expected 1 10", busy, m_clr);
    end
    apply_reset();
    run_clear(c);
    n_checks++;
    if (c != 32) begin
      n_fail++;
      $display("FAIL reset_in_clear_length: got %0d cycles expected 32", c);
    end
  endtask

  task automatic test_reset_run();
    int c;
    for (int r = 11; r <= 13; r++) begin
      issue_valid = 1'b1;
      issue_rd    = AW'(r);
      tick();
    end
    idle();
    wb_valid = 1'b1;
    wb_addr  = 5'd14;
    wb_data  = 32'hA5A5_0F0F;
    rs_addr  = 5'd11;
    rt_addr  = 5'd13;
    @(negedge clk);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_before_reset: got %b expected 1", hazard);
    end
    #6 apply_reset();
    run_clear(c);
    n_checks++;
    if (c != 32) begin
      n_fail++;
      $display("FAIL reset_in_run_length: got %0d cycles expected 32", c);
    end
    for (int r = 11; r <= 14; r++) begin
      rs_addr = AW'(r);
      rt_addr = 5'd5;
      @(negedge clk);
      n_checks++;
      if (hazard !== 1'b0 || rs_data !== '0 || rt_data !== '0) begin
        n_fail++;
        $display("FAIL after_run_reset_%0d: got hazard=%b rs=%h rt=%h expected 0 0 0",
                 r, hazard, rs_data, rt_data);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_same_cycle();
    test_zero_reg();
    test_random();
    test_reset_clear();
    test_reset_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
